// File: rtl/sram_access_arbiter.sv
// Purpose : two-port arbiter/sequencer for one asynchronous 16-bit SRAM (port 0 = CPU, port 1 = debug/loader).
// Latency : request sampled in IDLE at edge t -> doneN high in cycle t+2+WAIT_CYCLES; one IDLE cycle between grants.
// Backpr. : requesters hold req and fields stable until doneN; a losing requester simply waits in IDLE arbitration.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   req/we/addr/wdata/be{0,1}  per-port request and fields (sampled only in IDLE)
//   rdata{0,1}, done{0,1}      per-port read data (held) and one-cycle completion pulse
//   busy                       high whenever the sequencer is not IDLE
//   sram_*                     registered SRAM pins; sram_dq_i is the pad read data
//
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// undefined gives fixed priority with port 0 winning every tie.

module sram_access_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [15:0]       wdata0,
    input  logic [1:0]        be0,
    output logic [15:0]       rdata0,
    output logic              done0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata1,
    input  logic [1:0]        be1,
    output logic [15:0]       rdata1,
    output logic              done1,

    output logic              busy,

    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ACCESS counts down from WAIT_CYCLES-1 to 0; the zero cycle is the last one.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    // Fields of the granted request, frozen for the whole access.
    logic                lat_port_q, lat_port_d;
    logic                lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [15:0]         lat_wdata_q, lat_wdata_d;
    logic [1:0]          lat_be_q, lat_be_d;

    logic [15:0]         rdata0_q, rdata0_d;
    logic [15:0]         rdata1_q, rdata1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                ub_n_q, ub_n_d;
    logic                lb_n_q, lb_n_d;
    logic [15:0]         dq_o_q, dq_o_d;
    logic                dq_oe_q, dq_oe_d;

    // win = 1 selects port 1.
    logic                win;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = port 1 was granted last, so port 0 takes the next tie.
    logic                last_q, last_d;

    always_comb begin
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = ~req0;
        end
    end
`else
    always_comb begin
        win = ~req0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_port_d  = lat_port_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_be_d    = lat_be_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d     = ST_SETUP;
                    lat_port_d  = win;
                    lat_we_d    = win ? we1    : we0;
                    lat_addr_d  = win ? addr1  : addr0;
                    lat_wdata_d = win ? wdata1 : wdata0;
                    lat_be_d    = win ? be1    : be0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_d      = win;
`endif
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = WAIT_LAST;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    // Sample the pad at the end of the last strobe cycle so the data
                    // has had the full access window to settle.
                    if (!lat_we_q) begin
                        if (lat_port_q) begin
                            rdata1_d = sram_dq_i;
                        end else begin
                            rdata0_d = sram_dq_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values are decoded from the next state so every output is a flop
    // that already carries the value for the state being entered.
    always_comb begin
        addr_d  = addr_q;
        dq_o_d  = dq_o_q;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);

        case (state_d)
            ST_SETUP: begin
                ce_n_d  = 1'b0;
                addr_d  = lat_addr_d;
                dq_o_d  = lat_wdata_d;
                ub_n_d  = ~lat_be_d[1];
                lb_n_d  = ~lat_be_d[0];
                dq_oe_d = lat_we_d;
            end
            ST_ACCESS: begin
                ce_n_d  = 1'b0;
                ub_n_d  = ~lat_be_d[1];
                lb_n_d  = ~lat_be_d[0];
                // Exactly one strobe per access; a read never drives the pad.
                oe_n_d  = lat_we_d;
                we_n_d  = ~lat_we_d;
                dq_oe_d = lat_we_d;
            end
            ST_DONE: begin
                // Strobes released; address and data stay put for write hold time.
                dq_oe_d = lat_we_d;
                done0_d = ~lat_port_d;
                done1_d = lat_port_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            lat_port_q  <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_port_q  <= lat_port_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_be_q    <= lat_be_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign busy       = busy_q;
    assign sram_addr  = addr_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Purpose : scoreboard bench for sram_access_arbiter (ADDR_W=20, WAIT_CYCLES=2).
// Latency : each expected access is scheduled by cycle number when it is driven.
// Backpr. : requests are only driven when the bench's own schedule says the arbiter is idle.

module tb_sram_access_arbiter;

    localparam int AW   = 20;
    localparam int WAIT = 2;

    logic          clk;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [15:0]   wdata0, wdata1;
    logic [1:0]    be0, be1;
    logic [15:0]   rdata0, rdata1;
    logic          done0, done1, busy;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_i;

    sram_access_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(WAIT)) dut (
        .Clk(clk), .Reset(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
        .rdata0(rdata0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
        .rdata1(rdata1), .done1(done1),
        .busy(busy),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
    );

    typedef struct {
        int          port;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] rd;
        int          start;   // cycle in SETUP
        int          fin;     // cycle in DONE
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_rd [2];
    int          cyc;
    int          tb_last;     // port granted last (1 after reset)
    int          n_checks;
    int          n_errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    // Per-cycle monitor: every pin is compared against the scheduled access.
    task automatic mon_cycle();
        exp_t e;
        bit   in_t, sa, acc, at_fin;
        e      = '{port: 0, we: 0, addr: '0, wdata: '0, be: '0, rd: '0, start: 0, fin: 0};
        in_t   = 0;
        if (exp_q.size() > 0) begin
            e    = exp_q[0];
            in_t = (cyc >= e.start) && (cyc <= e.fin);
        end
        sa     = in_t && (cyc < e.fin);
        acc    = sa && (cyc > e.start);
        at_fin = in_t && (cyc == e.fin);

        check("busy",  busy,       in_t);
        check("ce_n",  sram_ce_n,  !sa);
        check("we_n",  sram_we_n,  !(acc && e.we));
        check("oe_n",  sram_oe_n,  !(acc && !e.we));
        check("dq_oe", sram_dq_oe, in_t && e.we);
        check("done0", done0,      at_fin && (e.port == 0));
        check("done1", done1,      at_fin && (e.port == 1));
        if (sa) begin
            check("ub_n", sram_ub_n, !e.be[1]);
            check("lb_n", sram_lb_n, !e.be[0]);
            check("addr", sram_addr, e.addr);
            if (e.we) check("dq_o", sram_dq_o, e.wdata);
        end
        if (at_fin) begin
            if (!e.we) exp_rd[e.port] = e.rd;
            void'(exp_q.pop_front());
        end
        check("rdata0", rdata0, exp_rd[0]);
        check("rdata1", rdata1, exp_rd[1]);
    endtask

    always @(posedge clk) begin
        #2;
        mon_cycle();
    end

    function automatic int tie_winner();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        return (tb_last == 1) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    task automatic drive_port(input int p, input bit w, input logic [19:0] a,
                              input logic [15:0] d, input logic [1:0] b);
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
        end
    endtask

    task automatic push_exp(input int p, input bit w, input logic [19:0] a, input logic [15:0] d,
                            input logic [1:0] b, input logic [15:0] rd, input int start);
        exp_q.push_back('{port: p, we: w, addr: a, wdata: d, be: b, rd: rd,
                          start: start, fin: start + WAIT + 1});
        tb_last = p;
    endtask

    // Called on a negedge while the arbiter is idle; the next posedge samples it.
    task automatic issue(input int p, input bit w, input logic [19:0] a, input logic [15:0] d,
                         input logic [1:0] b, input logic [15:0] rd);
        drive_port(p, w, a, d, b);
        if (!w) sram_dq_i = rd;
        push_exp(p, w, a, d, b, rd, cyc + 1);
    endtask

    // Waits to the negedge of the DONE cycle and releases both requests.
    task automatic wait_fin();
        repeat (WAIT + 2) @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Both ports requesting continuously for n accesses.
    task automatic tie_run(input int n);
        int c, p;
        c = cyc;
        drive_port(0, 1'b1, 20'h00100, 16'h7777, 2'b11);
        drive_port(1, 1'b0, 20'h00200, 16'h0000, 2'b11);
        sram_dq_i = 16'h1234;
        for (int k = 0; k < n; k++) begin
            p = tie_winner();
            if (p == 0) push_exp(0, 1'b1, 20'h00100, 16'h7777, 2'b11, 16'h0000, c + 1 + k * (WAIT + 3));
            else        push_exp(1, 1'b0, 20'h00200, 16'h0000, 2'b11, 16'h1234, c + 1 + k * (WAIT + 3));
        end
        repeat (n * (WAIT + 3) - 1) @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0; tb_last = 1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; be0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
        sram_dq_i = '0;

        repeat (3) @(negedge clk);
        check("rst_addr", sram_addr, 0);
        check("rst_ub_n", sram_ub_n, 1);
        check("rst_lb_n", sram_lb_n, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Port 0 full write, then port 1 read back
        issue(0, 1'b1, 20'h00010, 16'hBEEF, 2'b11, 16'h0000);
        wait_fin();
        @(negedge clk);
        issue(1, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'hBEEF);
        wait_fin();
        @(negedge clk);
        // Lower-byte write
        issue(0, 1'b1, 20'h00020, 16'h12AB, 2'b01, 16'h0000);
        wait_fin();
        @(negedge clk);
        // Read with no byte enables still captures the bus
        issue(0, 1'b0, 20'h00030, 16'h0000, 2'b00, 16'h5A5A);
        wait_fin();
        @(negedge clk);
        // req dropped in SETUP, fields scrambled: the latched access completes once
        issue(0, 1'b1, 20'h00044, 16'hA5C3, 2'b10, 16'h0000);
        @(negedge clk);
        req0 = 1'b0; addr0 = 20'hFFFFF; wdata0 = 16'h0000; be0 = 2'b01; we0 = 1'b0;
        wait_fin();
        repeat (6) @(negedge clk);

        // Both held: fixed priority serves only port 0, round-robin alternates
        tie_run(4);
        @(negedge clk);

        // Reset during the first ACCESS cycle of a write
        issue(0, 1'b1, 20'h00040, 16'hCAFE, 2'b11, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1; req0 = 1'b0;
        exp_q.delete();
        exp_rd[0] = '0; exp_rd[1] = '0;
        tb_last = 1;
        @(negedge clk);
        check("mid_rst_we_n", sram_we_n, 1);
        check("mid_rst_dq_oe", sram_dq_oe, 0);
        rst = 1'b0;
        @(negedge clk);
        issue(1, 1'b0, 20'h00077, 16'h0000, 2'b11, 16'h0F0F);
        wait_fin();
        @(negedge clk);
        // First tie after the above grant of port 1
        tie_run(1);
        repeat (4) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
